// File: rtl/wb_arbiter_pkg.sv
// Shared types and constants for the integer register-file write-back arbiter.
package wb_arbiter_pkg;

    localparam int REG_NUM   = 32;
    localparam int REG_IDX_W = 5;
    localparam int XLEN_DEF  = 32;

    // One buffered long-latency result: destination register plus its data.
    typedef struct packed {
        logic [REG_IDX_W-1:0] index;
        logic [XLEN_DEF-1:0]  data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO for long-latency write-back entries.
// Pushes are dropped when full and pops are ignored when empty, so callers
// may drive push/pop without pre-qualifying them.
module wb_fifo
    import wb_arbiter_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = wb_entry_t
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  entry_t                push_data,
    input  logic                  pop,
    output entry_t                head,
    output logic                  full,
    output logic                  empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    entry_t             mem_r [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [CNT_W-1:0]   count_r;
    logic               push_s;
    logic               pop_s;

    assign full   = (count_r == CNT_W'(DEPTH));
    assign empty  = (count_r == {CNT_W{1'b0}});
    assign count  = count_r;
    assign head   = mem_r[rd_ptr_r];
    assign push_s = push && !full;
    assign pop_s  = pop && !empty;

    // Entry storage: data needs no reset, occupancy is tracked by count_r.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
        end
    end

    // Occupancy counter; a simultaneous push and pop leaves it unchanged.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count_r <= {CNT_W{1'b0}};
        end else begin
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter for the register file's single write port.
// The in-order pipeline always wins; buffered long-latency results drain
// whenever the pipeline is not writing. A busy scoreboard tracks registers
// still owed by long-latency units so issue can stall on them.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   pipe_wen,
    input  logic [REG_IDX_W-1:0]   pipe_windex,
    input  logic [XLEN-1:0]        pipe_wdata,
    input  logic                   lq_valid,
    output logic                   lq_ready,
    input  logic [REG_IDX_W-1:0]   lq_index,
    input  logic [XLEN-1:0]        lq_data,
    input  logic                   alloc_en,
    input  logic [REG_IDX_W-1:0]   alloc_index,
    input  logic [REG_IDX_W-1:0]   chk_index1,
    input  logic [REG_IDX_W-1:0]   chk_index2,
    output logic                   chk_busy1,
    output logic                   chk_busy2,
    output logic                   wreg_en,
    output logic [REG_IDX_W-1:0]   wreg_index,
    output logic [XLEN-1:0]        wdata,
    output logic [$clog2(DEPTH):0] fifo_count
);

    // Same layout as wb_entry_t, but sized by this instance's XLEN.
    typedef struct packed {
        logic [REG_IDX_W-1:0] index;
        logic [XLEN-1:0]      data;
    } entry_t;

    entry_t             push_entry_s;
    entry_t             head_s;
    logic               full_s;
    logic               empty_s;
    logic               pipe_wr_s;
    logic               drain_s;
    logic               push_s;
    logic [REG_NUM-1:0] busy_r;
    logic [REG_NUM-1:0] busy_nxt_s;

    assign push_entry_s = {lq_index, lq_data};
    // Ready is derived from registered occupancy only, never from lq_valid.
    assign lq_ready     = reset && !full_s;
    // Results for x0 complete the handshake but are simply dropped.
    assign push_s       = lq_valid && lq_ready && (lq_index != 5'd0);

    wb_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_s),
        .push_data (push_entry_s),
        .pop       (drain_s),
        .head      (head_s),
        .full      (full_s),
        .empty     (empty_s),
        .count     (fifo_count)
    );

    // Write-port select: pipeline first, then FIFO head; x0 writes are void.
    always_comb begin
        pipe_wr_s  = pipe_wen && (pipe_windex != 5'd0);
        drain_s    = 1'b0;
        wreg_en    = 1'b0;
        wreg_index = 5'd0;
        wdata      = {XLEN{1'b0}};
        if (!reset) begin
            drain_s = 1'b0;
        end else if (pipe_wr_s) begin
            wreg_en    = 1'b1;
            wreg_index = pipe_windex;
            wdata      = pipe_wdata;
        end else if (!empty_s) begin
            drain_s    = 1'b1;
            wreg_en    = 1'b1;
            wreg_index = head_s.index;
            wdata      = head_s.data;
        end else begin
            wreg_en = 1'b0;
        end
    end

    // Scoreboard next state: drain clears, allocation sets and wins ties.
    always_comb begin
        busy_nxt_s = busy_r;
        if (drain_s) begin
            busy_nxt_s[head_s.index] = 1'b0;
        end else begin
            busy_nxt_s = busy_r;
        end
        if (alloc_en && (alloc_index != 5'd0)) begin
            busy_nxt_s[alloc_index] = 1'b1;
        end else begin
            busy_nxt_s[0] = 1'b0;
        end
        busy_nxt_s[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            busy_r <= {REG_NUM{1'b0}};
        end else begin
            busy_r <= busy_nxt_s;
        end
    end

    // Operand queries; a register draining this cycle is forwarded, so not busy.
    always_comb begin
        chk_busy1 = 1'b0;
        chk_busy2 = 1'b0;
        if (reset) begin
            chk_busy1 = busy_r[chk_index1] && !(drain_s && (head_s.index == chk_index1));
            chk_busy2 = busy_r[chk_index2] && !(drain_s && (head_s.index == chk_index2));
        end else begin
            chk_busy1 = 1'b0;
            chk_busy2 = 1'b0;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: a queue/array reference model predicts
// every cycle's outputs, and a negedge monitor compares them against the DUT.
module tb_wb_arbiter;

    localparam int DEPTH = 4;
    localparam int XLEN  = 32;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic            clk = 1'b0;
    logic            reset;
    logic            pipe_wen;
    logic [4:0]      pipe_windex;
    logic [XLEN-1:0] pipe_wdata;
    logic            lq_valid;
    logic            lq_ready;
    logic [4:0]      lq_index;
    logic [XLEN-1:0] lq_data;
    logic            alloc_en;
    logic [4:0]      alloc_index;
    logic [4:0]      chk_index1;
    logic [4:0]      chk_index2;
    logic            chk_busy1;
    logic            chk_busy2;
    logic            wreg_en;
    logic [4:0]      wreg_index;
    logic [XLEN-1:0] wdata;
    logic [CW-1:0]   fifo_count;

    typedef struct {
        bit          wen;
        logic [4:0]  idx;
        logic [31:0] data;
        bit          ready;
        int          count;
        bit          count_known;
        bit          b1;
        bit          b2;
    } exp_t;

    typedef struct {
        logic [4:0]  idx;
        logic [31:0] data;
    } ent_t;

    exp_t exp_q[$];
    ent_t mq[$];
    bit   mbusy[32];
    bit   known = 1'b0;
    int   tests = 0;
    int   fails = 0;

    wb_arbiter #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk         (clk),
        .reset       (reset),
        .pipe_wen    (pipe_wen),
        .pipe_windex (pipe_windex),
        .pipe_wdata  (pipe_wdata),
        .lq_valid    (lq_valid),
        .lq_ready    (lq_ready),
        .lq_index    (lq_index),
        .lq_data     (lq_data),
        .alloc_en    (alloc_en),
        .alloc_index (alloc_index),
        .chk_index1  (chk_index1),
        .chk_index2  (chk_index2),
        .chk_busy1   (chk_busy1),
        .chk_busy2   (chk_busy2),
        .wreg_en     (wreg_en),
        .wreg_index  (wreg_index),
        .wdata       (wdata),
        .fifo_count  (fifo_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, req);
        end
    endtask

    // Monitor: compares DUT outputs with the queued prediction every cycle.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("wreg_en", wreg_en, e.wen);
            if (e.wen) begin
                chk("wreg_index", wreg_index, e.idx);
                chk("wdata", wdata, e.data);
            end
            chk("lq_ready", lq_ready, e.ready);
            chk("chk_busy1", chk_busy1, e.b1);
            chk("chk_busy2", chk_busy2, e.b2);
            if (e.count_known) begin
                chk("fifo_count", fifo_count, e.count);
            end
        end
    end

    // Predict this cycle from the model, advance one clock, then update the model.
    task automatic step();
        exp_t e;
        bit   pipe;
        bit   drain;
        pipe          = pipe_wen && (pipe_windex != 5'd0);
        drain         = 1'b0;
        e.count       = mq.size();
        e.count_known = known;
        e.wen = 1'b0; e.idx = 5'd0; e.data = 32'd0;
        e.ready = 1'b0; e.b1 = 1'b0; e.b2 = 1'b0;
        if (reset) begin
            if (pipe && mbusy[pipe_windex]) begin
                fails++;
                $display("FAIL waw_protocol at %0t: pipe write to busy x%0d", $time, pipe_windex);
            end
            e.ready = (mq.size() < DEPTH);
            if (pipe) begin
                e.wen = 1'b1; e.idx = pipe_windex; e.data = pipe_wdata;
            end else if (mq.size() > 0) begin
                drain = 1'b1;
                e.wen = 1'b1; e.idx = mq[0].idx; e.data = mq[0].data;
            end
            e.b1 = mbusy[chk_index1] && !(drain && (e.idx == chk_index1));
            e.b2 = mbusy[chk_index2] && !(drain && (e.idx == chk_index2));
        end
        exp_q.push_back(e);
        @(posedge clk);
        if (!reset) begin
            mq.delete();
            foreach (mbusy[i]) mbusy[i] = 1'b0;
            known = 1'b1;
        end else begin
            if (drain) begin
                mbusy[mq[0].idx] = 1'b0;
                void'(mq.pop_front());
            end
            if (lq_valid && e.ready && (lq_index != 5'd0)) begin
                mq.push_back('{lq_index, lq_data});
            end
            if (alloc_en && (alloc_index != 5'd0)) begin
                mbusy[alloc_index] = 1'b1;
            end
        end
        #1;
    endtask

    task automatic idle();
        pipe_wen = 1'b0; pipe_windex = 5'd0; pipe_wdata = 32'd0;
        lq_valid = 1'b0; lq_index = 5'd0; lq_data = 32'd0;
        alloc_en = 1'b0; alloc_index = 5'd0;
    endtask

    task automatic lq(input logic [4:0] idx, input logic [31:0] d);
        lq_valid = 1'b1; lq_index = idx; lq_data = d;
    endtask

    task automatic alloc(input logic [4:0] idx);
        alloc_en = 1'b1; alloc_index = idx; step(); alloc_en = 1'b0;
    endtask

    initial begin
        reset = 1'b0; chk_index1 = 5'd0; chk_index2 = 5'd0;
        idle();
        @(posedge clk); #1;
        step(); step();
        reset = 1'b1;
        step();

        // Single long-latency result, pipe idle.
        alloc(5'd5);
        chk_index1 = 5'd5; chk_index2 = 5'd5;
        lq(5'd5, 32'hDEAD_BEEF); step();
        idle(); step(); step();

        // Fill while the pipeline holds the port, then drain in order.
        for (int k = 0; k < 4; k++) alloc(5'(10 + k));
        chk_index1 = 5'd10; chk_index2 = 5'd13;
        pipe_wen = 1'b1; pipe_windex = 5'd1; pipe_wdata = 32'h1111_0001;
        for (int k = 0; k < 4; k++) begin
            lq(5'(10 + k), 32'hA000_0000 + 32'(k)); step();
        end
        lq(5'd14, 32'hBAD0_0014); step();
        idle();
        for (int k = 0; k < 5; k++) step();

        // Push and pop together at count 2, then wrap the pointers.
        pipe_wen = 1'b1; pipe_windex = 5'd1; pipe_wdata = 32'h2222_0002;
        lq(5'd3, 32'hC000_0001); step();
        lq(5'd4, 32'hC000_0002); step();
        pipe_wen = 1'b0;
        lq(5'd6, 32'hC000_0003); step();
        for (int k = 0; k < 10; k++) begin
            lq(5'($urandom_range(31, 1)), $urandom); step();
        end
        idle();
        for (int k = 0; k < 4; k++) step();

        // Scoreboard: set, clear on drain, and set winning over clear.
        chk_index1 = 5'd7; chk_index2 = 5'd0;
        alloc(5'd7);
        step();
        lq(5'd7, 32'h7777_0001); step();
        idle(); step(); step();
        alloc(5'd7);
        lq(5'd7, 32'h7777_0002); step();
        idle(); alloc_en = 1'b1; alloc_index = 5'd7; step();
        idle(); step();
        lq(5'd7, 32'h7777_0003); step();
        idle(); step(); step();

        // Index-0 corner cases.
        pipe_wen = 1'b1; pipe_windex = 5'd1; lq(5'd9, 32'h9999_0009); step();
        lq_valid = 1'b0; pipe_windex = 5'd0; step();
        idle(); lq(5'd0, 32'h0BAD_0000); step();
        idle(); chk_index1 = 5'd0; chk_index2 = 5'd0; step();

        // Reset with three entries queued and busy bits set.
        alloc(5'd20); alloc(5'd21);
        chk_index1 = 5'd20; chk_index2 = 5'd21;
        pipe_wen = 1'b1; pipe_windex = 5'd1;
        lq(5'd20, 32'h2020_0020); step();
        lq(5'd21, 32'h2121_0021); step();
        lq(5'd22, 32'h2222_0022); step();
        pipe_wen = 1'b0; reset = 1'b0; lq(5'd23, 32'h2323_0023); step(); step();
        reset = 1'b1; idle(); step(); step();

        // Randomized traffic.
        for (int n = 0; n < 2000; n++) begin
            logic [4:0] p;
            idle();
            if ($urandom_range(99) < 40) begin
                p = 5'($urandom_range(7));
                pipe_wen = 1'b1;
                pipe_windex = mbusy[p] ? 5'd0 : p;
                pipe_wdata = $urandom;
            end
            if ($urandom_range(99) < 50) begin
                lq(($urandom_range(3) == 0) ? 5'($urandom_range(31)) : 5'($urandom_range(7)), $urandom);
            end
            if ($urandom_range(99) < 30) begin
                alloc_en = 1'b1; alloc_index = 5'($urandom_range(7));
            end
            chk_index1 = 5'($urandom_range(7));
            chk_index2 = 5'($urandom_range(7));
            reset = ($urandom_range(199) != 0);
            step();
        end
        reset = 1'b1; idle();
        for (int k = 0; k < 6; k++) step();
        @(negedge clk); #1;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
